// File: rtl/set_job_if.sv
// Host and hit-test bus of the set-candidate job scheduler.
// slave  : scheduler side.
// master : host plus hit-test unit side.
interface set_job_if;
   logic        en;
   logic [23:0] central;
   logic [11:0] radius;
   logic [1:0]  mode;
   logic        busy;
   logic        valid;
   logic [7:0]  candidate;
   logic [23:0] circ_xy;
   logic [11:0] circ_r;
   logic [3:0]  pt_x;
   logic [3:0]  pt_y;
   logic        pt_vld;
   logic [2:0]  hit;

   modport slave (
      input  en, central, radius, mode, hit,
      output busy, valid, candidate, circ_xy, circ_r, pt_x, pt_y, pt_vld
   );

   modport master (
      output en, central, radius, mode, hit,
      input  busy, valid, candidate, circ_xy, circ_r, pt_x, pt_y, pt_vld
   );
endinterface

// File: rtl/set_job_sched.sv
// set_job_sched: streams the 64 grid points (x,y in 1..8) of one job to a
// shared 3-circle hit-test unit, combines the returned hit vectors by mode
// and reports the hit count with a one-cycle valid.
//
// Optional build macro SET_JOB_QUEUE_EN adds a one-entry pending job slot so
// a second job can be accepted while one is running.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no active job, waiting for en
// ISSUE  | issuing grid points idx 0..63, one per cycle
// DRAIN  | all points issued, waiting for outstanding hit results
// DONE   | valid/candidate presented for one cycle
module set_job_sched #(
   parameter int HIT_LAT = 1
) (
   input logic      clk,
   input logic      rst,
   set_job_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [5:0]           idx_q, idx_d;
   logic [6:0]           acc_q, acc_d;
   logic [HIT_LAT-1:0]   tag_q, tag_d;
   logic [1:0]           mode_q, mode_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic [7:0]           cand_q, cand_d;
   logic [23:0]          circ_xy_q, circ_xy_d;
   logic [11:0]          circ_r_q, circ_r_d;
   logic [3:0]           pt_x_q, pt_x_d;
   logic [3:0]           pt_y_q, pt_y_d;
   logic                 pt_vld_q, pt_vld_d;
   logic                 start_host;
   logic                 start_slot;
   logic                 hit_inc;

`ifdef SET_JOB_QUEUE_EN
   logic                 pend_q, pend_d;
   logic [23:0]          pend_xy_q, pend_xy_d;
   logic [11:0]          pend_r_q, pend_r_d;
   logic [1:0]           pend_mode_q, pend_mode_d;
   logic                 load_slot;
`endif

   // Mode combine: bits outside the selected function are ignored.
   function automatic logic f_hit(input logic [1:0] m, input logic [2:0] h);
      case (m)
         2'b00:   return h[2];
         2'b01:   return h[2] & h[1];
         2'b10:   return h[2] ^ h[1];
         default: return (h == 3'b110) || (h == 3'b101) || (h == 3'b011);
      endcase
   endfunction

   // Hit is only counted when the tag line says a real point produced it.
   assign hit_inc = tag_q[HIT_LAT-1] & f_hit(mode_q, bus.hit);

   // Next-state logic for the FSM, point generator, tags and accumulator.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mode_d     = mode_q;
      valid_d    = valid_q;
      cand_d     = cand_q;
      circ_xy_d  = circ_xy_q;
      circ_r_d   = circ_r_q;
      pt_x_d     = pt_x_q;
      pt_y_d     = pt_y_q;
      pt_vld_d   = pt_vld_q;
      busy_d     = busy_q;
      start_host = 1'b0;
      start_slot = 1'b0;
      acc_d      = acc_q + {6'd0, hit_inc};
      tag_d[0]   = pt_vld_q;
      for (int i = 1; i < HIT_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
`ifdef SET_JOB_QUEUE_EN
      pend_d      = pend_q;
      pend_xy_d   = pend_xy_q;
      pend_r_d    = pend_r_q;
      pend_mode_d = pend_mode_q;
      load_slot   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.en) start_host = 1'b1;
         end
         S_ISSUE: begin
`ifdef SET_JOB_QUEUE_EN
            if (bus.en && !pend_q) load_slot = 1'b1;
`endif
            if (idx_q == 6'd63) begin
               pt_vld_d = 1'b0;
               state_d  = S_DRAIN;
            end else begin
               idx_d  = idx_q + 6'd1;
               pt_x_d = {1'b0, idx_d[2:0]} + 4'd1;
               pt_y_d = {1'b0, idx_d[5:3]} + 4'd1;
            end
         end
         S_DRAIN: begin
`ifdef SET_JOB_QUEUE_EN
            if (bus.en && !pend_q) load_slot = 1'b1;
`endif
            // The last tag is consumed this cycle, so acc_d is final.
            if (tag_d == '0) begin
               state_d = S_DONE;
               valid_d = 1'b1;
               cand_d  = {1'b0, acc_d};
            end
         end
         S_DONE: begin
            valid_d = 1'b0;
            state_d = S_IDLE;
`ifdef SET_JOB_QUEUE_EN
            // The slot frees as it is promoted, so it can refill in the same cycle.
            if (pend_q) begin
               start_slot = 1'b1;
               if (bus.en) load_slot = 1'b1;
            end else if (bus.en) begin
               start_host = 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (start_host) begin
         circ_xy_d = bus.central;
         circ_r_d  = bus.radius;
         mode_d    = bus.mode;
      end

`ifdef SET_JOB_QUEUE_EN
      if (start_slot) begin
         circ_xy_d = pend_xy_q;
         circ_r_d  = pend_r_q;
         mode_d    = pend_mode_q;
         pend_d    = 1'b0;
      end
      if (load_slot) begin
         pend_d      = 1'b1;
         pend_xy_d   = bus.central;
         pend_r_d    = bus.radius;
         pend_mode_d = bus.mode;
      end
`endif

      if (start_host || start_slot) begin
         state_d  = S_ISSUE;
         acc_d    = 7'd0;
         idx_d    = 6'd0;
         pt_x_d   = 4'd1;
         pt_y_d   = 4'd1;
         pt_vld_d = 1'b1;
      end

`ifdef SET_JOB_QUEUE_EN
      // Busy only while the slot is full; it drops for the DONE cycle because
      // the slot is promoted at the end of it.
      busy_d = pend_d && (state_d != S_DONE);
`else
      busy_d = (state_d != S_IDLE);
`endif
   end

   // State registers; reset aborts any job and clears the tag line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= 6'd0;
         acc_q       <= 7'd0;
         tag_q       <= '0;
         mode_q      <= 2'b00;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         cand_q      <= 8'd0;
         circ_xy_q   <= 24'd0;
         circ_r_q    <= 12'd0;
         pt_x_q      <= 4'd1;
         pt_y_q      <= 4'd1;
         pt_vld_q    <= 1'b0;
`ifdef SET_JOB_QUEUE_EN
         pend_q      <= 1'b0;
         pend_xy_q   <= 24'd0;
         pend_r_q    <= 12'd0;
         pend_mode_q <= 2'b00;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         tag_q       <= tag_d;
         mode_q      <= mode_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         cand_q      <= cand_d;
         circ_xy_q   <= circ_xy_d;
         circ_r_q    <= circ_r_d;
         pt_x_q      <= pt_x_d;
         pt_y_q      <= pt_y_d;
         pt_vld_q    <= pt_vld_d;
`ifdef SET_JOB_QUEUE_EN
         pend_q      <= pend_d;
         pend_xy_q   <= pend_xy_d;
         pend_r_q    <= pend_r_d;
         pend_mode_q <= pend_mode_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.valid     = valid_q;
   assign bus.candidate = cand_q;
   assign bus.circ_xy   = circ_xy_q;
   assign bus.circ_r    = circ_r_q;
   assign bus.pt_x      = pt_x_q;
   assign bus.pt_y      = pt_y_q;
   assign bus.pt_vld    = pt_vld_q;

endmodule

// File: tb/tb_set_job_sched.sv
// Bench for set_job_sched: two instances (HIT_LAT=1 and 3) share the host
// stimulus; each has its own reference hit-test model.
module tb_set_job_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   set_job_if if1 ();
   set_job_if if3 ();

   set_job_sched #(.HIT_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   set_job_sched #(.HIT_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   int nerr = 0;
   int nchk = 0;

`ifdef SET_JOB_QUEUE_EN
   localparam int BUSY_ACT = 0;
`else
   localparam int BUSY_ACT = 1;
`endif

   typedef struct {
      logic [23:0] c;
      logic [11:0] r;
      logic [1:0]  m;
      int          exp;
   } vec_t;

   vec_t vecs [10];

   // Reference hit test; idle slots return all-ones so untagged hits would be visible.
   function automatic logic [2:0] calc(input logic v, input logic [23:0] xy,
                                       input logic [11:0] r, input logic [3:0] px,
                                       input logic [3:0] py);
      logic [2:0] h;
      h = 3'b111;
      if (v) begin
         for (int i = 0; i < 3; i++) begin
            int cx, cy, rr, dx, dy;
            cx = int'(xy[23-8*i -: 4]);
            cy = int'(xy[19-8*i -: 4]);
            rr = int'(r[11-4*i -: 4]);
            dx = int'(px) - cx;
            dy = int'(py) - cy;
            h[2-i] = (dx*dx + dy*dy <= rr*rr);
         end
      end
      return h;
   endfunction

   logic [2:0] p1 = 3'b111;
   logic [2:0] p3 [3] = '{default: 3'b111};

   always @(posedge clk) begin
      p1    <= calc(if1.pt_vld, if1.circ_xy, if1.circ_r, if1.pt_x, if1.pt_y);
      p3[0] <= calc(if3.pt_vld, if3.circ_xy, if3.circ_r, if3.pt_x, if3.pt_y);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   assign if1.hit = p1;
   assign if3.hit = p3[2];

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_host(input logic e, input logic [23:0] c, input logic [11:0] r,
                           input logic [1:0] m);
      if1.en = e; if1.central = c; if1.radius = r; if1.mode = m;
      if3.en = e; if3.central = c; if3.radius = r; if3.mode = m;
   endtask

   task automatic chk_reset(input string t);
      chk({t, " d1 flags"}, int'({if1.valid, if1.busy, if1.pt_vld}), 0);
      chk({t, " d1 pt"},    int'({if1.pt_x, if1.pt_y}), 'h11);
      chk({t, " d1 cand"},  int'(if1.candidate), 0);
      chk({t, " d1 cxy"},   int'(if1.circ_xy), 0);
      chk({t, " d1 cr"},    int'(if1.circ_r), 0);
      chk({t, " d3 flags"}, int'({if3.valid, if3.busy, if3.pt_vld}), 0);
      chk({t, " d3 pt"},    int'({if3.pt_x, if3.pt_y}), 'h11);
      chk({t, " d3 cand"},  int'(if3.candidate), 0);
      chk({t, " d3 cxy"},   int'(if3.circ_xy), 0);
      chk({t, " d3 cr"},    int'(if3.circ_r), 0);
   endtask

   // One job launched at edge 0; pa/pb are cycles in which an extra en is pulsed.
   task automatic run_job(input int vi, input int pa, input int pb, input string t);
      int f1 = -1, l1 = -1, np1 = 0, nv1 = 0, vc1 = -1, cd1 = -1, bf1 = -1, bv1 = -1;
      int np3 = 0, nv3 = 0, vc3 = -1, cd3 = -1;
      @(negedge clk);
      set_host(1'b1, vecs[vi].c, vecs[vi].r, vecs[vi].m);
      @(posedge clk); #1;
      for (int n = 1; n <= 75; n++) begin
         if (if1.pt_vld) begin
            if (f1 < 0) f1 = n;
            l1 = n;
            np1++;
         end
         if (if1.valid) begin
            nv1++; vc1 = n; cd1 = int'(if1.candidate); bv1 = int'(if1.busy);
         end
         if (n == 1) bf1 = int'(if1.busy);
         if (if3.pt_vld) np3++;
         if (if3.valid) begin
            nv3++; vc3 = n; cd3 = int'(if3.candidate);
         end
         if (n == pa || n == pb)
            set_host(1'b1, 24'h110000, 12'hF00, 2'b00);
         else
            set_host(1'b0, ~vecs[vi].c, ~vecs[vi].r, ~vecs[vi].m);
         @(posedge clk); #1;
      end
      chk({t, " d1 cand"},   cd1, vecs[vi].exp);
      chk({t, " d1 vcyc"},   vc1, 66);
      chk({t, " d1 first"},  f1, 1);
      chk({t, " d1 last"},   l1, 64);
      chk({t, " d1 npt"},    np1, 64);
      chk({t, " d1 nval"},   nv1, 1);
      chk({t, " d1 hold"},   int'(if1.candidate), vecs[vi].exp);
      chk({t, " d1 busy1"},  bf1, BUSY_ACT);
      chk({t, " d1 busyv"},  bv1, BUSY_ACT);
      chk({t, " d1 busyend"}, int'(if1.busy), 0);
      chk({t, " d3 cand"},   cd3, vecs[vi].exp);
      chk({t, " d3 vcyc"},   vc3, 68);
      chk({t, " d3 npt"},    np3, 64);
      chk({t, " d3 nval"},   nv3, 1);
   endtask

   initial begin
      int nv, np;
      vecs[0] = '{24'h440000, 12'h200, 2'b00, 13};
      vecs[1] = '{24'h444400, 12'h220, 2'b01, 13};
      vecs[2] = '{24'h444400, 12'h220, 2'b10, 0};
      vecs[3] = '{24'h444488, 12'h220, 2'b11, 13};
      vecs[4] = '{24'h444444, 12'h222, 2'b11, 0};
      vecs[5] = '{24'h110000, 12'h000, 2'b00, 1};
      vecs[6] = '{24'h110000, 12'hF00, 2'b00, 64};
      vecs[7] = '{24'h441100, 12'h2F0, 2'b10, 51};
      vecs[8] = '{24'h884444, 12'h0FF, 2'b00, 1};
      vecs[9] = '{24'h114488, 12'hF20, 2'b11, 14};

      set_host(1'b0, 24'h0, 12'h0, 2'b00);
      #12;
      chk_reset("por");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_job(i, -1, -1, $sformatf("v%0d", i));
      end

`ifndef SET_JOB_QUEUE_EN
      // en pulses in ISSUE and in DONE (d1) are dropped.
      run_job(0, 5, 66, "drop");
`endif

      // Reset in cycle 30 of a job.
      @(negedge clk);
      set_host(1'b1, vecs[6].c, vecs[6].r, vecs[6].m);
      @(posedge clk); #1;
      set_host(1'b0, 24'h0, 12'h0, 2'b00);
      repeat (29) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk_reset("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      np = 0;
      for (int n = 0; n < 80; n++) begin
         @(posedge clk); #1;
         if (if1.valid || if3.valid) nv++;
         if (if1.pt_vld || if3.pt_vld) np++;
      end
      chk("postrst nval", nv, 0);
      chk("postrst npt", np, 0);
      run_job(0, -1, -1, "afterrst");

`ifdef SET_JOB_QUEUE_EN
      begin
         int nq1 = 0, nq3 = 0, fj2 = -1, b5 = -1, b11 = -1;
         int vq [2] = '{-1, -1};
         int cq [2] = '{-1, -1};
         int cq3 [2] = '{-1, -1};
         @(negedge clk);
         set_host(1'b1, vecs[0].c, vecs[0].r, vecs[0].m);
         @(posedge clk); #1;
         set_host(1'b0, 24'h0, 12'h0, 2'b00);
         for (int n = 1; n <= 200; n++) begin
            if (if1.valid) begin
               if (nq1 < 2) begin
                  vq[nq1] = n;
                  cq[nq1] = int'(if1.candidate);
               end
               nq1++;
            end
            if (if3.valid) begin
               if (nq3 < 2) cq3[nq3] = int'(if3.candidate);
               nq3++;
            end
            if (if1.pt_vld && nq1 == 1 && fj2 < 0) fj2 = n;
            if (n == 5) b5 = int'(if1.busy);
            if (n == 11) b11 = int'(if1.busy);
            if (n == 10)
               set_host(1'b1, vecs[6].c, vecs[6].r, vecs[6].m);
            else if (n == 20)
               set_host(1'b1, vecs[5].c, vecs[5].r, vecs[5].m);
            else
               set_host(1'b0, 24'h0, 12'h0, 2'b00);
            @(posedge clk); #1;
         end
         chk("q d1 nval", nq1, 2);
         chk("q d1 v0cyc", vq[0], 66);
         chk("q d1 c0", cq[0], 13);
         chk("q d1 j2first", fj2, 67);
         chk("q d1 v1cyc", vq[1], 132);
         chk("q d1 c1", cq[1], 64);
         chk("q d1 busy5", b5, 0);
         chk("q d1 busy11", b11, 1);
         chk("q d3 nval", nq3, 2);
         chk("q d3 c0", cq3[0], 13);
         chk("q d3 c1", cq3[1], 64);
      end
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
